// File: rtl/pipe_stall_ctrl_if.sv
// rtl/pipe_stall_ctrl_if.sv - stall request / stall bus bundle between pipeline stages and the stall sequencer
interface pipe_stall_ctrl_if;
    logic       stallreq_for_id;
    logic       stallreq_for_ex;
    logic       br_e_in;
    logic       br_e_out;
    logic [5:0] stall;
    logic       inst_hold;

    modport master (
        output stallreq_for_id,
        output stallreq_for_ex,
        output br_e_in,
        input  br_e_out,
        input  stall,
        input  inst_hold
    );

    modport slave (
        input  stallreq_for_id,
        input  stallreq_for_ex,
        input  br_e_in,
        output br_e_out,
        output stall,
        output inst_hold
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - pipeline stall sequencer with replay flag, branch gating, watchdog; STALL_PERF_EN adds stall counters
module pipe_stall_ctrl #(
    parameter int STALL_MAX = 64,
    parameter int CNT_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    pipe_stall_ctrl_if.slave   bus,
    output logic               stall_timeout,
    output logic [1:0]         ctrl_state,
    output logic [31:0]        perf_id_stall,
    output logic [31:0]        perf_ex_stall
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        ID_STALL = 2'd1,
        EX_STALL = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam logic [5:0]       STALL_ID = 6'b000111;
    localparam logic [5:0]       STALL_EX = 6'b001111;
    localparam logic [CNT_W-1:0] WD_SAT   = '1;
    localparam logic [CNT_W-1:0] WD_TRIP  = CNT_W'(STALL_MAX - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] wd_cnt;
    logic             stall_any;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = RUN;
        if (bus.stallreq_for_ex) begin
            state_nxt = EX_STALL;
        end else if (bus.stallreq_for_id) begin
            state_nxt = ID_STALL;
        end else if (state == ID_STALL) begin
            state_nxt = RELEASE;
        end
    end

    // Stall bus is Mealy on the live requests; reset forces everything quiet.
    always_comb begin
        bus.stall     = 6'b000000;
        bus.br_e_out  = 1'b0;
        bus.inst_hold = (state == RELEASE);
        ctrl_state    = state;
        if (rst) begin
            if (bus.stallreq_for_ex) begin
                bus.stall = STALL_EX;
            end else if (bus.stallreq_for_id) begin
                bus.stall = STALL_ID;
            end
            bus.br_e_out = bus.br_e_in & ~bus.stall[2];
        end
    end

    assign stall_any = |bus.stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt        <= '0;
            stall_timeout <= 1'b0;
        end else begin
            if (!stall_any) begin
                wd_cnt <= '0;
            end else if (wd_cnt != WD_SAT) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (stall_any && (wd_cnt == WD_TRIP)) begin
                stall_timeout <= 1'b1;
            end
        end
    end

`ifdef STALL_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_id_stall <= 32'h0;
            perf_ex_stall <= 32'h0;
        end else begin
            if ((bus.stall == STALL_ID) && (perf_id_stall != 32'hFFFF_FFFF)) begin
                perf_id_stall <= perf_id_stall + 32'd1;
            end
            if ((bus.stall == STALL_EX) && (perf_ex_stall != 32'hFFFF_FFFF)) begin
                perf_ex_stall <= perf_ex_stall + 32'd1;
            end
        end
    end
`else
    assign perf_id_stall = 32'h0;
    assign perf_ex_stall = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - randomized and directed bench for pipe_stall_ctrl against a request-history model
module tb_pipe_stall_ctrl;
    localparam int STALL_MAX = 4;

    logic        clk;
    logic        rst;
    logic        stall_timeout;
    logic [1:0]  ctrl_state;
    logic [31:0] perf_id_stall;
    logic [31:0] perf_ex_stall;
    int          n_cmp;
    int          n_fail;

    pipe_stall_ctrl_if bus ();

    pipe_stall_ctrl #(.STALL_MAX(STALL_MAX), .CNT_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .stall_timeout (stall_timeout),
        .ctrl_state    (ctrl_state),
        .perf_id_stall (perf_id_stall),
        .perf_ex_stall (perf_ex_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: request class per cycle (0 none, 1 ID only, 2 EX) plus the last two cycles' classes.
    int m_h1, m_h2, m_run, m_pid, m_pex;
    bit m_to;
    int cur_code;

    always_comb begin
        cur_code = 0;
        if (rst && bus.stallreq_for_ex) cur_code = 2;
        else if (rst && bus.stallreq_for_id) cur_code = 1;
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_h1 <= 0; m_h2 <= 0; m_run <= 0; m_to <= 1'b0; m_pid <= 0; m_pex <= 0;
        end else begin
            m_h2  <= m_h1;
            m_h1  <= cur_code;
            m_run <= (cur_code != 0) ? m_run + 1 : 0;
            if (cur_code != 0 && m_run + 1 >= STALL_MAX) m_to <= 1'b1;
            if (cur_code == 1) m_pid <= m_pid + 1;
            if (cur_code == 2) m_pex <= m_pex + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : cmp
        logic [5:0] e_stall;
        logic       e_hold;
        logic [1:0] e_state;
        e_stall = (cur_code == 2) ? 6'b001111 : (cur_code == 1) ? 6'b000111 : 6'b000000;
        e_hold  = (m_h2 == 1) && (m_h1 == 0);
        e_state = (m_h1 == 2) ? 2'd2 : (m_h1 == 1) ? 2'd1 : e_hold ? 2'd3 : 2'd0;
        chk("stall", 32'(bus.stall), 32'(e_stall));
        chk("br_e_out", 32'(bus.br_e_out), 32'(rst & bus.br_e_in & (cur_code == 0)));
        chk("inst_hold", 32'(bus.inst_hold), 32'(e_hold));
        chk("ctrl_state", 32'(ctrl_state), 32'(e_state));
        chk("stall_timeout", 32'(stall_timeout), 32'(m_to));
`ifdef STALL_PERF_EN
        chk("perf_id", perf_id_stall, 32'(m_pid));
        chk("perf_ex", perf_ex_stall, 32'(m_pex));
`else
        chk("perf_id", perf_id_stall, 32'h0);
        chk("perf_ex", perf_ex_stall, 32'h0);
`endif
    end

    task automatic step(input logic r, input logic id, input logic ex, input logic br);
        @(posedge clk);
        #1;
        rst = r;
        bus.stallreq_for_id = id;
        bus.stallreq_for_ex = ex;
        bus.br_e_in = br;
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst = 1'b0;
        bus.stallreq_for_id = 1'b0;
        bus.stallreq_for_ex = 1'b1;
        bus.br_e_in = 1'b1;

        step(0, 0, 1, 1);
        chk("rst_stall", 32'(bus.stall), 32'h0);
        chk("rst_br", 32'(bus.br_e_out), 32'h0);
        chk("rst_state", 32'(ctrl_state), 32'h0);
        chk("rst_to", 32'(stall_timeout), 32'h0);
        step(1, 0, 1, 1);
        chk("rel_stall", 32'(bus.stall), 32'h0F);
        chk("rel_state", 32'(ctrl_state), 32'h0);
        step(1, 0, 0, 0);
        chk("ex_state", 32'(ctrl_state), 32'h2);
        chk("ex_nohold", 32'(bus.inst_hold), 32'h0);
        step(1, 0, 0, 0);

        step(1, 1, 0, 1);
        chk("id_stall", 32'(bus.stall), 32'h07);
        chk("id_br", 32'(bus.br_e_out), 32'h0);
        step(1, 0, 0, 1);
        chk("id_state", 32'(ctrl_state), 32'h1);
        chk("id_br_free", 32'(bus.br_e_out), 32'h1);
        step(1, 0, 0, 0);
        chk("rel_hold", 32'(bus.inst_hold), 32'h1);
        chk("rel_state3", 32'(ctrl_state), 32'h3);
        step(1, 0, 0, 0);
        chk("run_hold", 32'(bus.inst_hold), 32'h0);

        step(1, 1, 1, 1);
        chk("both_stall", 32'(bus.stall), 32'h0F);
        chk("both_br", 32'(bus.br_e_out), 32'h0);
        step(1, 1, 0, 1);
        chk("idonly_stall", 32'(bus.stall), 32'h07);
        chk("idonly_br", 32'(bus.br_e_out), 32'h0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);

        repeat (3) step(1, 0, 1, 0);
        step(1, 0, 0, 0);
        chk("wd3_to", 32'(stall_timeout), 32'h0);
        repeat (2) step(1, 0, 1, 0);
        step(1, 0, 0, 0);
        repeat (3) step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        chk("wd_gap_to", 32'(stall_timeout), 32'h0);

        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 1, 0);
            chk("wd_run_to", 32'(stall_timeout), 32'(i >= 4));
        end
        step(1, 0, 0, 0);
        chk("wd_sticky", 32'(stall_timeout), 32'h1);
`ifdef STALL_PERF_EN
        chk("perf_ex5", perf_ex_stall, 32'd5);
`endif
        repeat (3) step(1, 0, 0, 0);
        chk("wd_sticky2", 32'(stall_timeout), 32'h1);
        step(0, 0, 0, 0);
        chk("wd_clr", 32'(stall_timeout), 32'h0);
        step(1, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 150) != 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)));
        end
        step(1, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
